// File: rtl/cam_pixel_assembler.sv
// ============================================================================
// cam_pixel_assembler : camera byte-pair to RGB888 pixel assembler with
//                       row-aligned frame-buffer write addressing.
// Optional macro CAM_TESTPAT_EN adds a test_pattern input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cam_pixel_assembler #(
  parameter int H_ACTIVE = 320,
  parameter int V_ACTIVE = 240,
  parameter int ADDR_W   = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        p_data,
`ifdef CAM_TESTPAT_EN
  input  logic              test_pattern,
`endif
  output logic [23:0]       pixel_data,
  output logic              pixel_valid,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic              frame_done,
  output logic              busy,
  output logic              overflow
);

  // Counters are at least 8 bits wide so the test-pattern slices always exist.
  localparam int COL_W  = ($clog2(H_ACTIVE + 1) > 8) ? $clog2(H_ACTIVE + 1) : 8;
  localparam int LINE_W = ($clog2(V_ACTIVE + 1) > 8) ? $clog2(V_ACTIVE + 1) : 8;

  localparam logic [COL_W-1:0]  H_LIM  = COL_W'(H_ACTIVE);
  localparam logic [LINE_W-1:0] V_LIM  = LINE_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_ACTIVE);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic              vsync_s1_q, vsync_s1_d, vsync_s2_q, vsync_s2_d;
  logic              href_s1_q, href_s1_d, href_s2_q, href_s2_d;
  logic [7:0]        data_s1_q, data_s1_d;
  logic [1:0]        state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [23:0]       pixel_data_q, pixel_data_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic              vs_rise, vs_fall, href_fall, use_pattern;
  logic [15:0]       rgb565;
  logic [23:0]       rgb888;

  assign vs_rise   = vsync_s1_q & ~vsync_s2_q;
  assign vs_fall   = ~vsync_s1_q & vsync_s2_q;
  assign href_fall = ~href_s1_q & href_s2_q;

`ifdef CAM_TESTPAT_EN
  assign use_pattern = test_pattern;
`else
  assign use_pattern = 1'b0;
`endif

  assign rgb565 = {hi_q, data_s1_q};
  assign rgb888 = {rgb565[15:11], rgb565[15:13],
                   rgb565[10:5],  rgb565[10:9],
                   rgb565[4:0],   rgb565[4:2]};

  always_comb begin
    vsync_s1_d    = vsync;
    href_s1_d     = href;
    data_s1_d     = p_data;
    vsync_s2_d    = vsync_s1_q;
    href_s2_d     = href_s1_q;
    state_d       = state_q;
    phase_d       = phase_q;
    hi_d          = hi_q;
    col_d         = col_q;
    line_d        = line_q;
    base_d        = base_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    addr_d        = addr_q;
    frame_done_d  = frame_done_q;
    overflow_d    = overflow_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d      = ST_WAIT;
          frame_done_d = 1'b0;
          overflow_d   = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b0;
          overflow_d   = 1'b0;
        end else if (vs_fall) begin
          col_d   = '0;
          line_d  = '0;
          base_d  = '0;
          phase_d = 1'b0;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (!enable) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b0;
          overflow_d   = 1'b0;
        end else begin
          if (href_s1_q) begin
            if (!phase_q) begin
              hi_d    = data_s1_q;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              if (col_q < H_LIM && line_q < V_LIM) begin
                pixel_valid_d = 1'b1;
                addr_d        = base_q + ADDR_W'(col_q);
                pixel_data_d  = use_pattern ? {col_q[7:0], line_q[7:0], 8'hA5} : rgb888;
                col_d         = col_q + 1'b1;
              end else begin
                overflow_d = 1'b1;
              end
            end
          end else if (href_fall) begin
            // Closing the line drops any unpaired byte and realigns to the next row.
            phase_d = 1'b0;
            col_d   = '0;
            if (line_q < V_LIM) begin
              line_d = line_q + 1'b1;
              base_d = base_q + H_STEP;
            end
          end
          if (vs_rise) begin
            frame_done_d = 1'b1;
            state_d      = ST_DONE;
          end
        end
      end
      default: begin
        if (!enable) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b0;
          overflow_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_s1_q    <= 1'b0;
      href_s1_q     <= 1'b0;
      data_s1_q     <= '0;
      vsync_s2_q    <= 1'b0;
      href_s2_q     <= 1'b0;
      state_q       <= ST_IDLE;
      phase_q       <= 1'b0;
      hi_q          <= '0;
      col_q         <= '0;
      line_q        <= '0;
      base_q        <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      addr_q        <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      vsync_s1_q    <= vsync_s1_d;
      href_s1_q     <= href_s1_d;
      data_s1_q     <= data_s1_d;
      vsync_s2_q    <= vsync_s2_d;
      href_s2_q     <= href_s2_d;
      state_q       <= state_d;
      phase_q       <= phase_d;
      hi_q          <= hi_d;
      col_q         <= col_d;
      line_q        <= line_d;
      base_q        <= base_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      addr_q        <= addr_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign addr        = addr_q;
  assign rw          = pixel_valid_q;
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q == ST_WAIT) || (state_q == ST_ACTIVE);

endmodule

`default_nettype wire
